// File: rtl/instr_buffer_reader_pkg.sv
// Shared definitions for the instruction buffer reader: FSM states and
// pointer width derivation.
package instr_buffer_reader_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // One extra MSB beyond the index distinguishes a full buffer from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_buffer_reader_skid_fifo.sv
// Two-entry output queue. It holds the instruction presented downstream and
// one entry of slack so that reads can stay pipelined against backpressure.
module instr_skid_fifo #(
  parameter int Instr_word_size = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Instr_word_size-1:0] data_in,
  output logic [Instr_word_size-1:0] data_out,
  output logic [1:0]                 count
);

  logic [1:0]                 count_q, count_d;
  logic [Instr_word_size-1:0] head_q, head_d;
  logic [Instr_word_size-1:0] tail_q, tail_d;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_in;
        else                 tail_d = data_in;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push and pop: count holds, order is preserved.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_in;
        end else begin
          head_d = data_in;
        end
      end
      default: ;
    endcase
    if (clr) count_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 2'd0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // Empty queue presents zero so stale storage never leaks downstream.
  assign data_out = (count_q != 2'd0) ? head_q : '0;
  assign count    = count_q;

endmodule

// File: rtl/instr_buffer_reader.sv
// Reads instructions out of a circular buffer filled by a separate writer and
// streams them downstream through a valid/ready handshake, with flush support.
module instr_buffer_reader
  import instr_buffer_reader_pkg::*;
#(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16,
  localparam int PW             = ptr_width(bs),
  localparam int IW             = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PW-1:0]              wr_ptr,
  input  logic                       flush,
  output logic                       rd_en,
  output logic [IW-1:0]              rd_index,
  input  logic [Instr_word_size-1:0] rd_data,
  output logic [Instr_word_size-1:0] instr_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [PW-1:0]              rd_ptr,
  output logic                       empty
);

  state_e        state_q, state_d;
  logic [PW-1:0] issue_ptr_q, issue_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;

  logic [PW-1:0] avail;
  logic [1:0]    q_count;
  logic [1:0]    occ_after_pop;
  logic          handshake;
  logic          push;
  logic          pop;

  assign avail         = wr_ptr - issue_ptr_q;
  assign handshake     = instr_valid && instr_ready;
  // A pop this cycle frees a slot, letting a new read overlap the transfer.
  assign occ_after_pop = {1'b0, inflight_q} + q_count - {1'b0, handshake};

  assign rd_en = !rst && (state_q == ST_RUN) && !flush &&
                 (avail != '0) && (occ_after_pop < 2'd2);

  // Data returning into a flush (or the FLUSH cycle itself) is dropped.
  assign push = inflight_q && (state_q == ST_RUN) && !flush;
  assign pop  = handshake && !flush;

  always_comb begin
    state_d     = ST_RUN;
    issue_ptr_d = issue_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = rd_en;
    if (flush) begin
      if (state_q == ST_RUN) state_d = ST_FLUSH;
      issue_ptr_d = wr_ptr;
      rd_ptr_d    = wr_ptr;
    end else begin
      if (rd_en) issue_ptr_d = issue_ptr_q + 1'b1;
      if (pop)   rd_ptr_d    = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      issue_ptr_q <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_ptr_q <= issue_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
    end
  end

  instr_skid_fifo #(
    .Instr_word_size(Instr_word_size)
  ) u_out_q (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push     (push),
    .pop      (pop),
    .data_in  (rd_data),
    .data_out (instr_out),
    .count    (q_count)
  );

  assign instr_valid = (q_count != 2'd0);
  assign rd_index    = issue_ptr_q[PW-2:0];
  assign rd_ptr      = rd_ptr_q;
  assign empty       = (wr_ptr == rd_ptr_q);

endmodule

// File: tb/tb_instr_buffer_reader.sv
// Bench for instr_buffer_reader: a buffer/writer model plus a scoreboard of
// written instructions, with directed scenarios followed by a random stream.
module tb_instr_buffer_reader;

  localparam int W  = 32;
  localparam int BS = 16;
  localparam int PW = $clog2(BS) + 1;
  localparam int IW = $clog2(BS);

  logic          clk;
  logic          rst;
  logic [PW-1:0] wr_ptr;
  logic          flush;
  logic          rd_en;
  logic [IW-1:0] rd_index;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [PW-1:0] rd_ptr;
  logic          empty;

  instr_buffer_reader #(.Instr_word_size(W), .bs(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ptr      (wr_ptr),
    .flush       (flush),
    .rd_en       (rd_en),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rd_ptr      (rd_ptr),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  mem [BS];
  logic [W-1:0]  sb [$];
  logic [IW-1:0] idx_log [$];
  logic [PW-1:0] exp_rd;
  logic [PW-1:0] exp_issue;
  int            occ;
  logic          hold_prev;
  logic [W-1:0]  prev_out;
  int            n_cmp;
  int            n_err;

  // Buffer read port: data one cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_index];
    else       rd_data <= $urandom();
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
    end
  endtask

  task automatic write_instr(input logic [W-1:0] w);
    mem[wr_ptr[PW-2:0]] = w;
    sb.push_back(w);
    wr_ptr = wr_ptr + 1'b1;
  endtask

  // Check one cycle against the model with the current inputs, then clock it.
  task automatic tick();
    logic hs;
    logic [W-1:0] e;
    #1;
    if (hold_prev) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_data", instr_out, prev_out);
    end
    chk("rd_ptr", rd_ptr, exp_rd);
    chk("empty", empty, wr_ptr == exp_rd);
    hs = instr_valid && instr_ready;
    if (rst || flush) begin
      chk("rd_en_gated", rd_en, 0);
    end else if (rd_en) begin
      chk("rd_index", rd_index, exp_issue[PW-2:0]);
      chk("no_overread", exp_issue != wr_ptr, 1);
      idx_log.push_back(rd_index);
    end
    if (hs && !flush && !rst) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", instr_out, 64'hdead);
      end else begin
        e = sb.pop_front();
        chk("instr_out", instr_out, e);
      end
    end
    hold_prev = instr_valid && !instr_ready && !flush && !rst;
    prev_out  = instr_out;
    if (rst) begin
      exp_rd = '0; exp_issue = '0; occ = 0; sb.delete();
    end else if (flush) begin
      exp_rd = wr_ptr; exp_issue = wr_ptr; occ = 0; sb.delete();
    end else begin
      if (rd_en) begin exp_issue = exp_issue + 1'b1; occ++; end
      if (hs)    begin exp_rd = exp_rd + 1'b1; occ--; end
      chk("occupancy", occ <= 2, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; wr_ptr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_idx [4];
  logic [PW-1:0] room;
  int guard;

  initial begin
    n_cmp = 0; n_err = 0; occ = 0; hold_prev = 1'b0; prev_out = '0;
    exp_rd = '0; exp_issue = '0;
    for (int i = 0; i < BS; i++) mem[i] = '0;
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; wr_ptr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_empty", empty, 1);

    // Three instructions, ready high: back-to-back reads and deliveries
    idx_log.delete();
    instr_ready = 1'b1;
    write_instr(32'hA000_000A);
    write_instr(32'hB000_000B);
    write_instr(32'hC000_000C);
    repeat (4) tick();
    chk("t1_sb_after4", sb.size(), 1);
    tick();
    chk("t1_sb_after5", sb.size(), 0);
    chk("t1_idx_cnt", idx_log.size(), 3);
    for (int i = 0; i < 3 && i < idx_log.size(); i++) chk("t1_idx", idx_log[i], i);
    chk("t1_rd_ptr", rd_ptr, 3);
    chk("t1_empty", empty, 1);

    // Backpressure: only two reads while ready is low
    do_reset();
    idx_log.delete();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_instr($urandom());
    repeat (6) tick();
    #1;
    chk("t2_reads", idx_log.size(), 2);
    chk("t2_rd_en", rd_en, 0);
    chk("t2_valid", instr_valid, 1);
    instr_ready = 1'b1;
    repeat (6) tick();
    chk("t2_sb", sb.size(), 0);
    chk("t2_rd_ptr", rd_ptr, 4);

    // Pointer wrap: start at 30 via flush, then four writes
    wr_ptr = PW'(30); flush = 1'b1;
    tick();
    flush = 1'b0;
    idx_log.delete();
    for (int i = 0; i < 4; i++) write_instr($urandom());
    repeat (8) tick();
    exp_idx = '{14, 15, 0, 1};
    chk("t3_idx_cnt", idx_log.size(), 4);
    for (int i = 0; i < 4 && i < idx_log.size(); i++) chk("t3_idx", idx_log[i], exp_idx[i]);
    chk("t3_rd_ptr", rd_ptr, 2);
    chk("t3_sb", sb.size(), 0);

    // Flush with a read in flight and a queued instruction
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 9; i++) write_instr($urandom());
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid", instr_valid, 0);
    chk("t4_rd_ptr", rd_ptr, 9);
    idx_log.delete();
    repeat (3) tick();
    chk("t4_no_reads", idx_log.size(), 0);
    chk("t4_still_empty", instr_valid, 0);
    write_instr(32'h1234_5678);
    repeat (4) tick();
    chk("t4_resume", idx_log.size(), 1);
    chk("t4_sb", sb.size(), 0);

    // Reset mid-stream with a read in flight
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_instr($urandom());
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    rst = 1'b1; wr_ptr = '0;
    tick();
    chk("t5_valid", instr_valid, 0);
    chk("t5_out", instr_out, 0);
    rst = 1'b0;
    write_instr(32'h5555_0001);
    write_instr(32'h5555_0002);
    repeat (6) tick();
    chk("t5_sb", sb.size(), 0);
    chk("t5_rd_ptr", rd_ptr, 2);

    // Random writer, random backpressure, occasional flush
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 2; k++) begin
          room = wr_ptr - exp_rd;
          if (room < PW'(BS)) write_instr($urandom());
        end
      end
      tick();
    end
    flush = 1'b0;
    instr_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0) && (guard < 100)) begin
      tick();
      guard++;
    end
    chk("drain_sb", sb.size(), 0);
    tick();
    chk("drain_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
